// File: rtl/mips_pkg.sv
// Shared constants for the MIPS ID/EX stage: opcodes, ex_ctrl bit layout,
// ALU-op encodings and default datapath widths.
package mips_pkg;

    localparam int MIPS_DW = 32;
    localparam int MIPS_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // ex_ctrl = {regwrite, memread, memwrite, alusrc, branch, funct_valid, aluop[1:0]}
    localparam int CTRL_W         = 8;
    localparam int CB_REGWRITE    = 7;
    localparam int CB_MEMREAD     = 6;
    localparam int CB_MEMWRITE    = 5;
    localparam int CB_ALUSRC      = 4;
    localparam int CB_BRANCH      = 3;
    localparam int CB_FUNCT_VALID = 2;
    localparam int CB_ALUOP_HI    = 1;
    localparam int CB_ALUOP_LO    = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    // Opcodes whose rt field is a source register rather than a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        logic r;
        case (op)
            OP_RTYPE: r = 1'b1;
            OP_SW:    r = 1'b1;
            OP_BEQ:   r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding selector: EX/MEM beats MEM/WB beats the register file.
// Register 0 is never forwarded.
module fwd_mux #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [DW-1:0] regdat,
    input  logic          exm_regwrite,
    input  logic [AW-1:0] exm_dest,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_dest,
    input  logic [DW-1:0] wb_dat,
    output logic [DW-1:0] opnd
);

    logic src_nz_s;

    assign src_nz_s = (src != '0);

    // Priority select of the newest producer of src.
    always_comb begin
        if (src_nz_s && exm_regwrite && (exm_dest == src)) begin
            opnd = exm_result;
        end else if (src_nz_s && wb_regwrite && (wb_dest == src)) begin
            opnd = wb_dat;
        end else begin
            opnd = regdat;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode stage: register-file addressing, operand forwarding, control
// decode, load-use detection and the ID/EX pipeline register.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW             = MIPS_DW,
    parameter int AW             = MIPS_AW,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   instr,
    input  logic [31:0]   pc_plus4,
    input  logic          stall,
    input  logic          flush,
    output logic [AW-1:0] readreg_1,
    output logic [AW-1:0] readreg_2,
    input  logic [DW-1:0] regdat_1,
    input  logic [DW-1:0] regdat_2,
    input  logic          exm_regwrite,
    input  logic [AW-1:0] exm_dest,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_dest,
    input  logic [DW-1:0] wb_dat,
    output logic          load_use_stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_opa,
    output logic [DW-1:0] ex_opb,
    output logic [DW-1:0] ex_imm,
    output logic [AW-1:0] ex_dest,
    output logic [7:0]    ex_ctrl,
    output logic [5:0]    ex_funct,
    output logic [31:0]   ex_pc_plus4,
    output logic          illegal
);

    logic [5:0]        opcode_s;
    logic [AW-1:0]     rs_s;
    logic [AW-1:0]     rt_s;
    logic [AW-1:0]     rd_s;
    logic [CTRL_W-1:0] dec_ctrl_s;
    logic [AW-1:0]     dec_dest_s;
    logic              dec_zext_s;
    logic              dec_illegal_s;
    logic [DW-1:0]     dec_imm_s;
    logic [DW-1:0]     fwd_a_s;
    logic [DW-1:0]     fwd_b_s;
    logic              lus_s;

    logic              ex_valid_d,   ex_valid_q;
    logic [CTRL_W-1:0] ex_ctrl_d,    ex_ctrl_q;
    logic [AW-1:0]     ex_dest_d,    ex_dest_q;
    logic [DW-1:0]     ex_opa_d,     ex_opa_q;
    logic [DW-1:0]     ex_opb_d,     ex_opb_q;
    logic [DW-1:0]     ex_imm_d,     ex_imm_q;
    logic [5:0]        ex_funct_d,   ex_funct_q;
    logic [31:0]       ex_pc_d,      ex_pc_q;
    logic              illegal_d,    illegal_q;

    assign opcode_s  = instr[31:26];
    assign rs_s      = AW'(instr[25:21]);
    assign rt_s      = AW'(instr[20:16]);
    assign rd_s      = AW'(instr[15:11]);
    assign readreg_1 = rs_s;
    assign readreg_2 = rt_s;

    // Opcode decode into control bits, destination and immediate style.
    always_comb begin
        dec_ctrl_s    = {CTRL_W{1'b0}};
        dec_dest_s    = {AW{1'b0}};
        dec_zext_s    = 1'b0;
        dec_illegal_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_ctrl_s[CB_REGWRITE]                = 1'b1;
                dec_ctrl_s[CB_FUNCT_VALID]             = 1'b1;
                dec_ctrl_s[CB_ALUOP_HI:CB_ALUOP_LO]    = ALUOP_FUNCT;
                dec_dest_s                             = rd_s;
            end
            OP_LW: begin
                dec_ctrl_s[CB_REGWRITE]                = 1'b1;
                dec_ctrl_s[CB_MEMREAD]                 = 1'b1;
                dec_ctrl_s[CB_ALUSRC]                  = 1'b1;
                dec_ctrl_s[CB_ALUOP_HI:CB_ALUOP_LO]    = ALUOP_ADD;
                dec_dest_s                             = rt_s;
            end
            OP_SW: begin
                dec_ctrl_s[CB_MEMWRITE]                = 1'b1;
                dec_ctrl_s[CB_ALUSRC]                  = 1'b1;
                dec_ctrl_s[CB_ALUOP_HI:CB_ALUOP_LO]    = ALUOP_ADD;
            end
            OP_BEQ: begin
                dec_ctrl_s[CB_BRANCH]                  = 1'b1;
                dec_ctrl_s[CB_ALUOP_HI:CB_ALUOP_LO]    = ALUOP_SUB;
            end
            OP_ADDI: begin
                dec_ctrl_s[CB_REGWRITE]                = 1'b1;
                dec_ctrl_s[CB_ALUSRC]                  = 1'b1;
                dec_ctrl_s[CB_ALUOP_HI:CB_ALUOP_LO]    = ALUOP_ADD;
                dec_dest_s                             = rt_s;
            end
            OP_ANDI, OP_ORI: begin
                // aluop=11 tells EX to take the logical op from the immediate path
                dec_ctrl_s[CB_REGWRITE]                = 1'b1;
                dec_ctrl_s[CB_ALUSRC]                  = 1'b1;
                dec_ctrl_s[CB_ALUOP_HI:CB_ALUOP_LO]    = ALUOP_LOGIC;
                dec_dest_s                             = rt_s;
                dec_zext_s                             = 1'b1;
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Immediate extension: zero for logical immediates, sign otherwise.
    always_comb begin
        if (dec_zext_s) begin
            dec_imm_s = {{(DW-16){1'b0}}, instr[15:0]};
        end else begin
            dec_imm_s = {{(DW-16){instr[15]}}, instr[15:0]};
        end
    end

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
        .src          (rs_s),
        .regdat       (regdat_1),
        .exm_regwrite (exm_regwrite),
        .exm_dest     (exm_dest),
        .exm_result   (exm_result),
        .wb_regwrite  (wb_regwrite),
        .wb_dest      (wb_dest),
        .wb_dat       (wb_dat),
        .opnd         (fwd_a_s)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
        .src          (rt_s),
        .regdat       (regdat_2),
        .exm_regwrite (exm_regwrite),
        .exm_dest     (exm_dest),
        .exm_result   (exm_result),
        .wb_regwrite  (wb_regwrite),
        .wb_dest      (wb_dest),
        .wb_dat       (wb_dat),
        .opnd         (fwd_b_s)
    );

    // A load in EX whose destination is a source of the decoding instruction.
    always_comb begin
        if (ex_valid_q && ex_ctrl_q[CB_MEMREAD] && (ex_dest_q != {AW{1'b0}})) begin
            lus_s = (ex_dest_q == rs_s) || ((ex_dest_q == rt_s) && uses_rt(opcode_s));
        end else begin
            lus_s = 1'b0;
        end
    end

    assign load_use_stall = lus_s;

    // ID/EX next state; data buses follow decode whenever not held.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_dest_d  = ex_dest_q;
        ex_opa_d   = ex_opa_q;
        ex_opb_d   = ex_opb_q;
        ex_imm_d   = ex_imm_q;
        ex_funct_d = ex_funct_q;
        ex_pc_d    = ex_pc_q;
        illegal_d  = illegal_q;
        if (flush || !stall) begin
            ex_opa_d   = fwd_a_s;
            ex_opb_d   = fwd_b_s;
            ex_imm_d   = dec_imm_s;
            ex_funct_d = instr[5:0];
            ex_pc_d    = pc_plus4;
            if (flush || lus_s || !in_valid) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = {CTRL_W{1'b0}};
                ex_dest_d  = {AW{1'b0}};
                illegal_d  = 1'b0;
            end else begin
                ex_valid_d = !(dec_illegal_s && NOP_ON_ILLEGAL);
                ex_ctrl_d  = dec_ctrl_s;
                ex_dest_d  = dec_dest_s;
                illegal_d  = dec_illegal_s;
            end
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // ID/EX pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= {CTRL_W{1'b0}};
            ex_dest_q  <= {AW{1'b0}};
            ex_opa_q   <= {DW{1'b0}};
            ex_opb_q   <= {DW{1'b0}};
            ex_imm_q   <= {DW{1'b0}};
            ex_funct_q <= 6'd0;
            ex_pc_q    <= 32'd0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_dest_q  <= ex_dest_d;
            ex_opa_q   <= ex_opa_d;
            ex_opb_q   <= ex_opb_d;
            ex_imm_q   <= ex_imm_d;
            ex_funct_q <= ex_funct_d;
            ex_pc_q    <= ex_pc_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_dest     = ex_dest_q;
    assign ex_opa      = ex_opa_q;
    assign ex_opb      = ex_opb_q;
    assign ex_imm      = ex_imm_q;
    assign ex_funct    = ex_funct_q;
    assign ex_pc_plus4 = ex_pc_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized + directed bench for id_ex_stage against a cycle-level reference
// model of the decode/forward/hazard rules.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        flush;
    logic [4:0]  readreg_1;
    logic [4:0]  readreg_2;
    logic [31:0] regdat_1;
    logic [31:0] regdat_2;
    logic        exm_regwrite;
    logic [4:0]  exm_dest;
    logic [31:0] exm_result;
    logic        wb_regwrite;
    logic [4:0]  wb_dest;
    logic [31:0] wb_dat;
    logic        load_use_stall;
    logic        ex_valid;
    logic [31:0] ex_opa;
    logic [31:0] ex_opb;
    logic [31:0] ex_imm;
    logic [4:0]  ex_dest;
    logic [7:0]  ex_ctrl;
    logic [5:0]  ex_funct;
    logic [31:0] ex_pc_plus4;
    logic        illegal;

    id_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .instr          (instr),
        .pc_plus4       (pc_plus4),
        .stall          (stall),
        .flush          (flush),
        .readreg_1      (readreg_1),
        .readreg_2      (readreg_2),
        .regdat_1       (regdat_1),
        .regdat_2       (regdat_2),
        .exm_regwrite   (exm_regwrite),
        .exm_dest       (exm_dest),
        .exm_result     (exm_result),
        .wb_regwrite    (wb_regwrite),
        .wb_dest        (wb_dest),
        .wb_dat         (wb_dat),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .ex_opa         (ex_opa),
        .ex_opb         (ex_opb),
        .ex_imm         (ex_imm),
        .ex_dest        (ex_dest),
        .ex_ctrl        (ex_ctrl),
        .ex_funct       (ex_funct),
        .ex_pc_plus4    (ex_pc_plus4),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit armed = 1'b0;
    logic last_lus;

    // Reference ID/EX state.
    logic        m_valid, m_illegal, m_data_chk;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_dest;
    logic [5:0]  m_funct;
    logic [31:0] m_opa, m_opb, m_imm, m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Control word per opcode: {regwrite,memread,memwrite,alusrc,branch,funct_valid,aluop}
    function automatic logic [8:0] ref_decode(input logic [5:0] op);
        case (op)
            6'h00:        return {1'b1, 8'b1000_0110};
            6'h23:        return {1'b1, 8'b1101_0000};
            6'h2B:        return {1'b1, 8'b0011_0000};
            6'h04:        return {1'b1, 8'b0000_1001};
            6'h08:        return {1'b1, 8'b1001_0000};
            6'h0C, 6'h0D: return {1'b1, 8'b1001_0011};
            default:      return {1'b0, 8'b0000_0000};
        endcase
    endfunction

    function automatic logic [4:0] ref_dest(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op == 6'h00) return ins[15:11];
        if (op == 6'h23 || op == 6'h08 || op == 6'h0C || op == 6'h0D) return ins[20:16];
        return 5'd0;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (src != 5'd0 && exm_regwrite && exm_dest == src) return exm_result;
        if (src != 5'd0 && wb_regwrite && wb_dest == src) return wb_dat;
        return rf;
    endfunction

    function automatic logic ref_lus();
        logic [5:0] op;
        logic rt_used;
        op = instr[31:26];
        rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return m_valid && m_ctrl[6] && (m_dest != 5'd0) &&
               ((m_dest == instr[25:21]) || (rt_used && m_dest == instr[20:16]));
    endfunction

    task automatic model_bubble();
        m_valid = 1'b0; m_ctrl = 8'h00; m_dest = 5'd0; m_illegal = 1'b0; m_data_chk = 1'b0;
    endtask

    task automatic model_update(input logic lus);
        logic [8:0] d;
        logic [15:0] imm16;
        if (rst) begin
            model_bubble();
            m_opa = 32'd0; m_opb = 32'd0; m_imm = 32'd0; m_funct = 6'd0; m_pc = 32'd0;
            m_data_chk = 1'b1;
        end else if (flush) begin
            model_bubble();
        end else if (stall) begin
            m_valid = m_valid;
        end else if (lus || !in_valid) begin
            model_bubble();
        end else begin
            d = ref_decode(instr[31:26]);
            imm16 = instr[15:0];
            m_illegal = !d[8];
            m_valid = d[8];
            m_ctrl = d[7:0];
            m_dest = d[8] ? ref_dest(instr) : 5'd0;
            m_opa = ref_fwd(instr[25:21], regdat_1);
            m_opb = ref_fwd(instr[20:16], regdat_2);
            if (instr[31:26] == 6'h0C || instr[31:26] == 6'h0D) m_imm = {16'd0, imm16};
            else m_imm = 32'($signed(imm16));
            m_funct = instr[5:0];
            m_pc = pc_plus4;
            m_data_chk = d[8];
        end
    endtask

    task automatic check_regs();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        chk("ex_dest", 32'(ex_dest), 32'(m_dest));
        chk("illegal", 32'(illegal), 32'(m_illegal));
        if (m_data_chk) begin
            chk("ex_opa", ex_opa, m_opa);
            chk("ex_opb", ex_opb, m_opb);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_funct", 32'(ex_funct), 32'(m_funct));
            chk("ex_pc_plus4", ex_pc_plus4, m_pc);
        end
    endtask

    // One clock: check combinational hazard, advance model, check registers.
    task automatic step();
        logic e_lus;
        #1;
        e_lus = ref_lus();
        if (armed) chk("load_use_stall", 32'(load_use_stall), 32'(e_lus));
        last_lus = load_use_stall;
        model_update(e_lus);
        @(posedge clk);
        #1;
        armed = 1'b1;
        check_regs();
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic quiet_fwd();
        exm_regwrite = 1'b0; exm_dest = 5'd0; exm_result = 32'd0;
        wb_regwrite = 1'b0; wb_dest = 5'd0; wb_dat = 32'd0;
    endtask

    logic [5:0] ops [8];

    initial begin
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h08; ops[5] = 6'h0C; ops[6] = 6'h0D; ops[7] = 6'h3F;
        rst = 1'b1; in_valid = 1'b1; instr = mk_r(5'd1, 5'd2, 5'd3);
        pc_plus4 = 32'h0000_0004; stall = 1'b0; flush = 1'b0;
        regdat_1 = 32'h1111_1111; regdat_2 = 32'h2222_2222;
        quiet_fwd();
        @(posedge clk); #1;

        // Reset with in_valid high.
        step(); step();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_ex_opa", ex_opa, 32'd0);
        rst = 1'b0;

        // EX/MEM forwarding onto rs.
        instr = mk_r(5'd1, 5'd2, 5'd3); regdat_1 = 32'd5; regdat_2 = 32'h1234;
        exm_regwrite = 1'b1; exm_dest = 5'd1; exm_result = 32'h77;
        step();
        chk("exm_fwd_opa", ex_opa, 32'h77);
        chk("exm_fwd_opb", ex_opb, 32'h1234);
        chk("exm_fwd_dest", 32'(ex_dest), 32'd3);

        // EX/MEM beats MEM/WB on the same register.
        exm_dest = 5'd2; exm_result = 32'hA; wb_regwrite = 1'b1; wb_dest = 5'd2; wb_dat = 32'hB;
        step();
        chk("prio_opb", ex_opb, 32'hA);
        chk("prio_opa", ex_opa, 32'd5);

        // Register 0 never forwarded.
        instr = mk_r(5'd0, 5'd0, 5'd3); regdat_1 = 32'h11; regdat_2 = 32'h22;
        exm_dest = 5'd0; wb_dest = 5'd0;
        step();
        chk("r0_opa", ex_opa, 32'h11);
        chk("r0_opb", ex_opb, 32'h22);

        // Load-use: lw $4 then add $5,$4,$6.
        quiet_fwd();
        instr = mk_i(6'h23, 5'd1, 5'd4, 16'h0);
        step();
        instr = mk_r(5'd4, 5'd6, 5'd5);
        step();
        chk("lu_stall_hi", 32'(last_lus), 32'd1);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        exm_regwrite = 1'b1; exm_dest = 5'd4; exm_result = 32'hCAFE;
        step();
        chk("lu_stall_lo", 32'(last_lus), 32'd0);
        chk("lu_issue_opa", ex_opa, 32'hCAFE);
        chk("lu_issue_valid", 32'(ex_valid), 32'd1);

        // Stall holds, flush beats stall.
        quiet_fwd();
        instr = mk_i(6'h08, 5'd1, 5'd7, 16'h0010);
        step();
        instr = mk_i(6'h0C, 5'd2, 5'd9, 16'h0FF0); stall = 1'b1;
        step();
        chk("stall_hold_imm", ex_imm, 32'h10);
        chk("stall_hold_dest", 32'(ex_dest), 32'd7);
        flush = 1'b1; instr = mk_i(6'h08, 5'd1, 5'd7, 16'h0020);
        step();
        chk("flush_stall_valid", 32'(ex_valid), 32'd0);
        flush = 1'b0;
        step();
        chk("stall_after_flush", 32'(ex_valid), 32'd0);
        stall = 1'b0;

        // Illegal opcode and immediate extension.
        instr = {6'h3F, 26'd0};
        step();
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_bubble", 32'(ex_valid), 32'd0);
        instr = mk_i(6'h0D, 5'd1, 5'd2, 16'h8000);
        step();
        chk("ori_zext", ex_imm, 32'h0000_8000);
        instr = mk_i(6'h08, 5'd1, 5'd2, 16'h8000);
        step();
        chk("addi_sext", ex_imm, 32'hFFFF_8000);

        // Randomized traffic; upstream usually holds its instruction when blocked.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 99) < 85);
            if (!((last_lus || stall) && $urandom_range(0, 3) != 0)) begin
                op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
                instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
                pc_plus4 = $urandom;
            end
            regdat_1 = $urandom; regdat_2 = $urandom;
            exm_regwrite = 1'($urandom); exm_dest = 5'($urandom_range(0, 7)); exm_result = $urandom;
            wb_regwrite = 1'($urandom); wb_dest = 5'($urandom_range(0, 7)); wb_dat = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode and operand-forwarding stage of the 5-stage MIPS pipeline.
- Takes the fetched instruction and drives the Register_file read addresses, which it reads combinationally.
- Forwards newer results from EX/MEM and MEM/WB, decodes the control fields, detects load-use hazards and registers everything into the ID/EX pipeline register.
- Its outputs feed the ALU/execute stage.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.
- NOP_ON_ILLEGAL, 1, when 1 an unknown opcode issues as a bubble and raises illegal.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  instr/pc_plus4 valid from IF/ID
- instr  input  32  instruction word
- pc_plus4  input  32  PC+4 of instr
- stall  input  1  external hold (e.g. memory wait); freezes ID/EX
- flush  input  1  branch-taken squash of the instruction in decode
- readreg_1  output  AW  rs = instr[25:21], combinational to Register_file
- readreg_2  output  AW  rt = instr[20:16], combinational to Register_file
- regdat_1  input  DW  Register_file data for readreg_1
- regdat_2  input  DW  Register_file data for readreg_2
- exm_regwrite  input  1  EX/MEM writes a register
- exm_dest  input  AW  EX/MEM destination
- exm_result  input  DW  EX/MEM ALU result
- wb_regwrite  input  1  MEM/WB write enable (same signal as Register_file regwrite)
- wb_dest  input  AW  MEM/WB destination (write_add)
- wb_dat  input  DW  MEM/WB data (write_dat)
- load_use_stall  output  1  combinational; upstream must hold PC and IF/ID
- ex_valid  output  1  ID/EX holds a real instruction
- ex_opa  output  DW  forwarded rs operand
- ex_opb  output  DW  forwarded rt operand
- ex_imm  output  DW  sign-extended instr[15:0]; zero-extended for ori/andi
- ex_dest  output  AW  rd for R-type, rt for I-type loads/ALU-imm, 0 otherwise
- ex_ctrl  output  8  {regwrite, memread, memwrite, alusrc, branch, funct_valid, aluop[1:0]}
- ex_funct  output  6  instr[5:0]
- ex_pc_plus4  output  32  registered pc_plus4
- illegal  output  1  registered; unknown opcode seen this issue

Behaviour:
- Reset: all registered outputs are 0, including ex_valid, ex_ctrl, illegal and the data buses. load_use_stall follows its equation; it is 0 because ex_valid=0.
- Latency: one cycle from decode to ID/EX outputs.
- Decoded opcodes:
  - 0x00 R-type: regwrite, aluop=10, dest=rd.
  - 0x23 lw: regwrite, memread, alusrc, aluop=00, dest=rt.
  - 0x2B sw: memwrite, alusrc, dest=0.
  - 0x04 beq: branch, aluop=01.
  - 0x08 addi: regwrite, alusrc, dest=rt.
  - 0x0C andi and 0x0D ori: regwrite, alusrc, zero-extended imm.
  - Any other opcode: illegal=1 and, if NOP_ON_ILLEGAL, a bubble.
- Forwarding per operand, priority high to low:
  - (a) exm_regwrite & exm_dest!=0 & exm_dest==src → exm_result.
  - (b) wb_regwrite & wb_dest!=0 & wb_dest==src → wb_dat. This covers a same-cycle register-file write not yet visible on the read port.
  - (c) otherwise regdat.
- Register 0 is never forwarded.
- Load-use stall: load_use_stall = ex_valid & ex_ctrl.memread & ex_dest!=0 & (ex_dest==rs | (ex_dest==rt & instruction uses rt)).
  - Instructions that use rt: R-type, sw, beq.
- Register update each cycle, first match wins:
  1. rst → clear.
  2. flush → ID/EX loaded with a bubble (ex_valid=0, ex_ctrl=0).
  3. stall → hold all registers. A load_use_stall is not raised again against a frozen pair; upstream already holds.
  4. load_use_stall → bubble inserted. The dependent instruction stays in IF/ID and issues the next cycle with the load result forwarded via exm.
  5. in_valid=0 → bubble.
  6. otherwise → load the decoded, forwarded values with ex_valid=1.
- Bubble definition: ex_valid=0, ex_ctrl=0, ex_dest=0. Data buses may hold stale values; verification checks them only when ex_valid=1.
- Reset mid-stall: reset wins and the pipeline register clears. flush together with stall: flush wins.

Decomposition:
- mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI);
  - the ex_ctrl bit-position constants and aluop encodings;
  - widths DW and AW.
- One sub-module, fwd_mux: a pure combinational per-operand priority selector, instantiated twice.
- Opcode decode stays inline.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → ex_valid=0, ex_ctrl=0, illegal=0, ex_opa=0.
- EX/MEM forward: instr add $3,$1,$2 with regdat_1=5 and exm_regwrite=1, exm_dest=1, exm_result=0x77 → next cycle ex_opa=0x77, ex_opb=regdat_2, ex_dest=3.
- Priority and $0 rules:
  - exm and wb both target $2 (exm_result=0xA, wb_dat=0xB) → ex_opb=0xA.
  - With exm_dest=0 and wb_dest=0 targeting $0 (values 0xA and 0xB), reading $0 yields regdat.
- Load-use: lw $4,0($1) issued, then add $5,$4,$6 → load_use_stall=1 for one cycle and a bubble enters ID/EX. Next cycle the add issues with ex_opa=exm_result.
- Flush vs stall: flush=1 and stall=1 with a valid addi → ex_valid=0. A following stall=1 alone holds the previous ex_* values unchanged.
- Illegal: opcode 0x3F → next cycle illegal=1 and ex_valid=0. Immediate check: ori imm=0x8000 gives ex_imm=0x00008000; addi imm=0x8000 gives 0xFFFF8000.
